ball_motion: RTL and testbench
==============================

// Module: ball_motion
// PURPOSE
//  Integrates ball position per frame from the speed magnitudes produced by ball_speed (b_sx/b_sy).
//  Owns direction, wall/paddle bounces and ball-lost detection; drives b_x/b_y/bd back into ball_speed and renderer.
//  Speed is magnitude only; this block supplies sign and decides when the ball is in flight (bd).
// PARAMETERS
//  SCREEN_W   640  visible width, px
//  SCREEN_H   480  visible height, px
//  BALL_R     4    ball radius, px
//  PADDLE_Y   440  paddle top surface row, px
//  FRAC_BITS  2    fractional bits of internal position; speed LSB = 2^-FRAC_BITS px/frame
// PORTS
//  clock        in   1   system clock
//  reset        in   1   asynchronous, active-high reset
//  tick         in   1   one-cycle frame strobe; all motion happens on tick cycles only
//  launch       in   1   one-cycle request: release ball from paddle
//  b_sx, b_sy   in   4   speed magnitudes from ball_speed (unsigned, FRAC_BITS fractional)
//  p_x          in   10  paddle centre x
//  p_radius     in   6   paddle half-width
//  brick_hit_x  in   1   brick collision on vertical face this frame (reverse x)
//  brick_hit_y  in   1   brick collision on horizontal face this frame (reverse y)
//  b_x, b_y     out  10  ball centre, integer px (internal position >> FRAC_BITS)
//  bd           out  1   ball in flight (1 only in MOVE)
//  b_dx, b_dy   out  1   direction: b_dx 1=right 0=left; b_dy 1=down 0=up
//  lost         out  1   one-cycle pulse when ball passes bottom edge
// BEHAVIOUR
//  Reset (async): state HOLD, b_x=SCREEN_W/2, b_y=PADDLE_Y-BALL_R, bd=0, b_dx=1, b_dy=0, lost=0.
//  States: HOLD (on paddle), MOVE (flight), LOST (one cycle).
//  HOLD: on tick b_x<=p_x, b_y<=PADDLE_Y-BALL_R. launch -> MOVE next cycle, b_dy=0; bd=1 registered same edge.
//   launch and tick same cycle: follow p_x this tick, enter MOVE; first step on next tick.
//   launch ignored in MOVE and LOST.
//  MOVE, on tick, in order:
//   1. brick_hit_x toggles b_dx, brick_hit_y toggles b_dy (both may apply).
//   2. step each axis: pos += or -= speed, computed FRAC_BITS+11 bits wide (one guard bit, no wrap).
//   3. left: result < BALL_R -> clamp BALL_R, b_dx=1. right: > SCREEN_W-1-BALL_R -> clamp, b_dx=0.
//   4. top: result < BALL_R -> clamp BALL_R, b_dy=1.
//   5. paddle: b_dy=1, result >= PADDLE_Y-BALL_R, and p_x-p_radius <= b_x < p_x+p_radius
//      -> clamp y to PADDLE_Y-BALL_R, b_dy=0, b_dx = (b_x < p_x) ? 0 : 1.
//   6. bottom: result > SCREEN_H-1-BALL_R -> state LOST, bd=0.
//   Corner hits: x and y rules apply independently in the same tick. Wall clamp overrides brick toggle on that axis.
//   Zero speed on an axis: position held, no bounce evaluated on that axis.
//  LOST: lost=1 for exactly this cycle; next cycle -> HOLD with reset position/direction values.
//  Outputs registered; position visible the cycle after tick. No tick -> no state change except launch.
// CONFIGURATION
//  BALL_MOTION_INVINCIBLE_EN defined: bottom edge clamps to SCREEN_H-1-BALL_R and sets b_dy=0;
//   LOST never entered, lost tied 0. Undefined: bottom edge behaves as rule 6.
// STRUCTURE
//  arkanoid_pkg: SCREEN_W/H, BALL_R, PADDLE_Y defaults; state enum {HOLD,MOVE,LOST};
//   DIR_LEFT/RIGHT/UP/DOWN constants.
//  Sub-module ball_axis_step (pos, speed, dir, lo, hi -> next_pos, hit_lo, hit_hi),
//   instantiated once per axis; paddle/bottom logic and FSM stay in ball_motion.
// TESTING
//  Reset mid-flight at b_x=300 -> next cycle b_x=320, b_y=436, bd=0, b_dx=1, b_dy=0.
//  HOLD, p_x=100, tick -> b_x=100; launch then 4 ticks at b_sx=b_sy=7 (1.75px) -> b_x=107, b_y=429, bd=1.
//  Ball near left wall x=5, b_dx=0, b_sx=15 -> b_x=4, b_dx=1; next tick b_x=7 (3.75 px, frac kept).
//  Descending, p_x=200, p_radius=20, ball x=190 reaches y=436 -> b_y=436, b_dy=0, b_dx=0.
//  Ball misses paddle, crosses y=475 -> bd=0, lost high exactly 1 cycle, then HOLD at paddle.
//  INVINCIBLE_EN build, same miss -> b_y=475, b_dy=0, lost stays 0, bd stays 1.

Source files
------------

// File: rtl/arkanoid_pkg.sv
// Shared constants for the Arkanoid playfield and ball logic:
// screen geometry defaults, ball FSM state encodings and direction codes.
package arkanoid_pkg;

  // Playfield geometry defaults (pixels)
  localparam int SCREEN_W_DEF  = 640;
  localparam int SCREEN_H_DEF  = 480;
  localparam int BALL_R_DEF    = 4;
  localparam int PADDLE_Y_DEF  = 440;
  localparam int FRAC_BITS_DEF = 2;

  // Ball FSM states
  localparam logic [1:0] HOLD = 2'd0;  // resting on paddle
  localparam logic [1:0] MOVE = 2'd1;  // in flight
  localparam logic [1:0] LOST = 2'd2;  // single cycle after passing the bottom edge

  // Direction codes: 1 means moving towards increasing coordinate
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;
  localparam logic DIR_UP    = 1'b0;
  localparam logic DIR_DOWN  = 1'b1;

endpackage

// File: rtl/ball_axis_step.sv
// One-axis fixed-point position integrator with low/high wall clamping.
// Signed step is evaluated one bit wider than the position so that a move
// below zero is detected as a low-wall hit instead of wrapping around.
// A zero speed holds the position and never reports a wall hit.
module ball_axis_step #(
  parameter int POS_W = 12,
  parameter int SPD_W = 4
) (
  input  logic [POS_W-1:0] pos,
  input  logic [SPD_W-1:0] speed,
  input  logic             dir,
  input  logic [POS_W-1:0] lo,
  input  logic [POS_W-1:0] hi,
  output logic [POS_W-1:0] next_pos,
  output logic             hit_lo,
  output logic             hit_hi
);

  logic [POS_W:0] step_s;

  // Step the position by the signed speed and clamp against the walls
  always_comb begin
    step_s   = {1'b0, pos};
    next_pos = pos;
    hit_lo   = 1'b0;
    hit_hi   = 1'b0;
    if (speed == {SPD_W{1'b0}}) begin
      next_pos = pos;
    end else if (dir) begin
      step_s = {1'b0, pos} + {{(POS_W+1-SPD_W){1'b0}}, speed};
      if (step_s > {1'b0, hi}) begin
        next_pos = hi;
        hit_hi   = 1'b1;
      end else begin
        next_pos = step_s[POS_W-1:0];
      end
    end else begin
      step_s = {1'b0, pos} - {{(POS_W+1-SPD_W){1'b0}}, speed};
      // MSB set means the result went negative
      if (step_s[POS_W] || (step_s < {1'b0, lo})) begin
        next_pos = lo;
        hit_lo   = 1'b1;
      end else begin
        next_pos = step_s[POS_W-1:0];
      end
    end
  end

endmodule

// File: rtl/ball_motion.sv
// Ball motion controller: integrates ball position each frame from the
// speed magnitudes, owns direction, wall/paddle bounces and ball-lost
// detection. Position is kept with FRAC_BITS fractional bits internally.
// Build option: define BALL_MOTION_INVINCIBLE_EN to make the bottom edge
// a bouncing wall (LOST is never entered and lost stays 0).
module ball_motion
  import arkanoid_pkg::*;
#(
  parameter int SCREEN_W  = SCREEN_W_DEF,
  parameter int SCREEN_H  = SCREEN_H_DEF,
  parameter int BALL_R    = BALL_R_DEF,
  parameter int PADDLE_Y  = PADDLE_Y_DEF,
  parameter int FRAC_BITS = FRAC_BITS_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick,
  input  logic       launch,
  input  logic [3:0] b_sx,
  input  logic [3:0] b_sy,
  input  logic [9:0] p_x,
  input  logic [5:0] p_radius,
  input  logic       brick_hit_x,
  input  logic       brick_hit_y,
  output logic [9:0] b_x,
  output logic [9:0] b_y,
  output logic       bd,
  output logic       b_dx,
  output logic       b_dy,
  output logic       lost
);

  localparam int POS_W = 10 + FRAC_BITS;

  // Fixed-point bounds and home positions
  localparam logic [POS_W-1:0] X_LO   = POS_W'(BALL_R << FRAC_BITS);
  localparam logic [POS_W-1:0] X_HI   = POS_W'((SCREEN_W - 1 - BALL_R) << FRAC_BITS);
  localparam logic [POS_W-1:0] Y_LO   = POS_W'(BALL_R << FRAC_BITS);
  localparam logic [POS_W-1:0] Y_HI   = POS_W'((SCREEN_H - 1 - BALL_R) << FRAC_BITS);
  localparam logic [POS_W-1:0] Y_REST = POS_W'((PADDLE_Y - BALL_R) << FRAC_BITS);
  localparam logic [POS_W-1:0] X_HOME = POS_W'((SCREEN_W / 2) << FRAC_BITS);

  logic [1:0]       state_r, state_s;
  logic [POS_W-1:0] pos_x_r, pos_x_s;
  logic [POS_W-1:0] pos_y_r, pos_y_s;
  logic             bd_r, bd_s;
  logic             dx_r, dx_s;
  logic             dy_r, dy_s;

  logic             x_dir_s, y_dir_s;
  logic [POS_W-1:0] x_next_s, y_next_s;
  logic             x_hit_lo_s, x_hit_hi_s;
  logic             y_hit_lo_s, y_hit_hi_s;
  logic [9:0]       x_next_px_s;
  logic             paddle_span_s;
  logic             paddle_hit_s;

  // Brick collisions reverse direction before the step is taken
  assign x_dir_s = dx_r ^ brick_hit_x;
  assign y_dir_s = dy_r ^ brick_hit_y;

  ball_axis_step #(.POS_W(POS_W), .SPD_W(4)) u_axis_x (
    .pos      (pos_x_r),
    .speed    (b_sx),
    .dir      (x_dir_s),
    .lo       (X_LO),
    .hi       (X_HI),
    .next_pos (x_next_s),
    .hit_lo   (x_hit_lo_s),
    .hit_hi   (x_hit_hi_s)
  );

  ball_axis_step #(.POS_W(POS_W), .SPD_W(4)) u_axis_y (
    .pos      (pos_y_r),
    .speed    (b_sy),
    .dir      (y_dir_s),
    .lo       (Y_LO),
    .hi       (Y_HI),
    .next_pos (y_next_s),
    .hit_lo   (y_hit_lo_s),
    .hit_hi   (y_hit_hi_s)
  );

  // Paddle span test on the stepped x, written without subtraction to avoid underflow
  assign x_next_px_s   = x_next_s[POS_W-1:FRAC_BITS];
  assign paddle_span_s = (({1'b0, x_next_px_s} + {5'd0, p_radius}) >= {1'b0, p_x}) &&
                         ({1'b0, x_next_px_s} < ({1'b0, p_x} + {5'd0, p_radius}));
  assign paddle_hit_s  = (y_dir_s == DIR_DOWN) && (b_sy != 4'd0) &&
                         (y_next_s >= Y_REST) && paddle_span_s;

`ifndef BALL_MOTION_INVINCIBLE_EN
  logic lost_r, lost_s;
`endif

  // Next-state logic for the ball FSM, position and direction
  always_comb begin
    state_s = state_r;
    pos_x_s = pos_x_r;
    pos_y_s = pos_y_r;
    bd_s    = bd_r;
    dx_s    = dx_r;
    dy_s    = dy_r;
`ifndef BALL_MOTION_INVINCIBLE_EN
    lost_s  = 1'b0;
`endif
    case (state_r)
      HOLD: begin
        if (tick) begin
          pos_x_s = {p_x, {FRAC_BITS{1'b0}}};
          pos_y_s = Y_REST;
        end else begin
          pos_x_s = pos_x_r;
        end
        if (launch) begin
          state_s = MOVE;
          bd_s    = 1'b1;
          dy_s    = DIR_UP;
        end else begin
          state_s = HOLD;
        end
      end
      MOVE: begin
        if (tick) begin
          pos_x_s = x_next_s;
          pos_y_s = y_next_s;
          if (x_hit_lo_s) begin
            dx_s = DIR_RIGHT;
          end else if (x_hit_hi_s) begin
            dx_s = DIR_LEFT;
          end else begin
            dx_s = x_dir_s;
          end
          if (y_hit_lo_s) begin
            dy_s = DIR_DOWN;
          end else begin
            dy_s = y_dir_s;
          end
          if (paddle_hit_s) begin
            pos_y_s = Y_REST;
            dy_s    = DIR_UP;
            dx_s    = (x_next_px_s < p_x) ? DIR_LEFT : DIR_RIGHT;
          end else if (y_hit_hi_s) begin
`ifdef BALL_MOTION_INVINCIBLE_EN
            dy_s    = DIR_UP;
`else
            state_s = LOST;
            bd_s    = 1'b0;
            lost_s  = 1'b1;
`endif
          end else begin
            state_s = MOVE;
          end
        end else begin
          state_s = MOVE;
        end
      end
      LOST: begin
        state_s = HOLD;
        pos_x_s = X_HOME;
        pos_y_s = Y_REST;
        bd_s    = 1'b0;
        dx_s    = DIR_RIGHT;
        dy_s    = DIR_UP;
      end
      default: begin
        state_s = HOLD;
        pos_x_s = X_HOME;
        pos_y_s = Y_REST;
        bd_s    = 1'b0;
        dx_s    = DIR_RIGHT;
        dy_s    = DIR_UP;
      end
    endcase
  end

  // Register FSM state, position and direction
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= HOLD;
      pos_x_r <= X_HOME;
      pos_y_r <= Y_REST;
      bd_r    <= 1'b0;
      dx_r    <= DIR_RIGHT;
      dy_r    <= DIR_UP;
    end else begin
      state_r <= state_s;
      pos_x_r <= pos_x_s;
      pos_y_r <= pos_y_s;
      bd_r    <= bd_s;
      dx_r    <= dx_s;
      dy_r    <= dy_s;
    end
  end

`ifdef BALL_MOTION_INVINCIBLE_EN
  assign lost = 1'b0;
`else
  // Register the one-cycle ball-lost pulse
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lost_r <= 1'b0;
    end else begin
      lost_r <= lost_s;
    end
  end

  assign lost = lost_r;
`endif

  assign b_x  = pos_x_r[POS_W-1:FRAC_BITS];
  assign b_y  = pos_y_r[POS_W-1:FRAC_BITS];
  assign bd   = bd_r;
  assign b_dx = dx_r;
  assign b_dy = dy_r;

endmodule

// File: tb/tb_ball_motion.sv
// Directed self-checking bench for ball_motion: reset values, paddle
// following, launch and integration with fractional speed, wall and paddle
// bounces, and ball-lost (or invincible bottom bounce when
// BALL_MOTION_INVINCIBLE_EN is defined).
module tb_ball_motion;

  logic       clock = 1'b0;
  logic       reset;
  logic       tick;
  logic       launch;
  logic [3:0] b_sx, b_sy;
  logic [9:0] p_x;
  logic [5:0] p_radius;
  logic       brick_hit_x, brick_hit_y;
  logic [9:0] b_x, b_y;
  logic       bd, b_dx, b_dy, lost;

  int n_cmp = 0;
  int n_err = 0;

  ball_motion dut (
    .clock       (clock),
    .reset       (reset),
    .tick        (tick),
    .launch      (launch),
    .b_sx        (b_sx),
    .b_sy        (b_sy),
    .p_x         (p_x),
    .p_radius    (p_radius),
    .brick_hit_x (brick_hit_x),
    .brick_hit_y (brick_hit_y),
    .b_x         (b_x),
    .b_y         (b_y),
    .bd          (bd),
    .b_dx        (b_dx),
    .b_dy        (b_dy),
    .lost        (lost)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idle();
    @(posedge clock);
    #1;
  endtask

  task automatic tick_once();
    tick = 1'b1;
    idle();
    tick = 1'b0;
    brick_hit_x = 1'b0;
    brick_hit_y = 1'b0;
  endtask

  task automatic launch_once();
    launch = 1'b1;
    idle();
    launch = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    reset = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    tick        = 1'b0;
    launch      = 1'b0;
    b_sx        = 4'd0;
    b_sy        = 4'd0;
    p_x         = 10'd0;
    p_radius    = 6'd0;
    brick_hit_x = 1'b0;
    brick_hit_y = 1'b0;
    idle();
    idle();

    // Reset state
    chk("rst_bx",   16'(b_x),  16'd320);
    chk("rst_by",   16'(b_y),  16'd436);
    chk("rst_bd",   16'(bd),   16'd0);
    chk("rst_dx",   16'(b_dx), 16'd1);
    chk("rst_dy",   16'(b_dy), 16'd0);
    chk("rst_lost", 16'(lost), 16'd0);
    reset = 1'b0;

    // Reset mid-flight at x=300 (asynchronous, before any clock edge)
    p_x = 10'd300;
    tick_once();
    chk("hold300_bx", 16'(b_x), 16'd300);
    launch_once();
    chk("fly300_bd", 16'(bd), 16'd1);
    reset = 1'b1;
    #2;
    chk("arst_bx", 16'(b_x),  16'd320);
    chk("arst_by", 16'(b_y),  16'd436);
    chk("arst_bd", 16'(bd),   16'd0);
    chk("arst_dx", 16'(b_dx), 16'd1);
    chk("arst_dy", 16'(b_dy), 16'd0);
    idle();
    reset = 1'b0;

    // HOLD follows paddle; launch; four steps of 1.75 px
    p_x = 10'd100;
    tick_once();
    chk("hold_bx", 16'(b_x), 16'd100);
    chk("hold_by", 16'(b_y), 16'd436);
    launch_once();
    chk("launch_bd", 16'(bd),  16'd1);
    chk("launch_bx", 16'(b_x), 16'd100);
    chk("launch_dy", 16'(b_dy), 16'd0);
    b_sx = 4'd7;
    b_sy = 4'd7;
    idle();
    chk("notick_bx", 16'(b_x), 16'd100);
    tick_once();
    chk("step1_bx", 16'(b_x), 16'd101);
    chk("step1_by", 16'(b_y), 16'd434);
    tick_once();
    tick_once();
    tick_once();
    chk("step4_bx", 16'(b_x), 16'd107);
    chk("step4_by", 16'(b_y), 16'd429);
    chk("step4_bd", 16'(bd),  16'd1);

    // Left wall: x=5, brick flips to left, 3.75 px step clamps to 4
    do_reset();
    p_x  = 10'd5;
    b_sx = 4'd0;
    b_sy = 4'd0;
    tick_once();
    launch_once();
    b_sx        = 4'd15;
    brick_hit_x = 1'b1;
    tick_once();
    chk("lwall_bx", 16'(b_x),  16'd4);
    chk("lwall_dx", 16'(b_dx), 16'd1);
    chk("lwall_by", 16'(b_y),  16'd436);
    tick_once();
    chk("lwall2_bx", 16'(b_x),  16'd7);
    chk("lwall2_dx", 16'(b_dx), 16'd1);

    // Right wall: x=634 + 3.75 px clamps to 635, turns left
    do_reset();
    p_x  = 10'd634;
    b_sx = 4'd0;
    tick_once();
    launch_once();
    b_sx = 4'd15;
    tick_once();
    chk("rwall_bx", 16'(b_x),  16'd635);
    chk("rwall_dx", 16'(b_dx), 16'd0);

    // Paddle bounce: x=190 on paddle centred at 200, descending
    do_reset();
    p_x  = 10'd190;
    b_sx = 4'd0;
    b_sy = 4'd0;
    tick_once();
    launch_once();
    p_x         = 10'd200;
    p_radius    = 6'd20;
    b_sy        = 4'd7;
    brick_hit_y = 1'b1;
    tick_once();
    chk("pad_by", 16'(b_y),  16'd436);
    chk("pad_dy", 16'(b_dy), 16'd0);
    chk("pad_dx", 16'(b_dx), 16'd0);
    chk("pad_bd", 16'(bd),   16'd1);

    // Top wall: climb from 436 at 3.75 px; 115 steps -> 4.75, 116th clamps
    b_sy = 4'd15;
    for (int i = 0; i < 115; i++) begin
      tick_once();
    end
    chk("top115_by", 16'(b_y),  16'd4);
    chk("top115_dy", 16'(b_dy), 16'd0);
    tick_once();
    chk("top_by", 16'(b_y),  16'd4);
    chk("top_dy", 16'(b_dy), 16'd1);

    // Miss the paddle and cross the bottom edge
    do_reset();
    p_x  = 10'd100;
    b_sx = 4'd0;
    b_sy = 4'd0;
    tick_once();
    launch_once();
    p_x         = 10'd500;
    p_radius    = 6'd20;
    b_sy        = 4'd15;
    brick_hit_y = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick_once();
    end
    chk("miss10_by",   16'(b_y),  16'd473);
    chk("miss10_bd",   16'(bd),   16'd1);
    chk("miss10_lost", 16'(lost), 16'd0);
    tick_once();
`ifdef BALL_MOTION_INVINCIBLE_EN
    chk("inv_by",   16'(b_y),  16'd475);
    chk("inv_dy",   16'(b_dy), 16'd0);
    chk("inv_lost", 16'(lost), 16'd0);
    chk("inv_bd",   16'(bd),   16'd1);
    idle();
    chk("inv2_lost", 16'(lost), 16'd0);
    chk("inv2_bd",   16'(bd),   16'd1);
    chk("inv2_by",   16'(b_y),  16'd475);
`else
    chk("lost_bd",   16'(bd),   16'd0);
    chk("lost_lost", 16'(lost), 16'd1);
    idle();
    chk("after_lost", 16'(lost), 16'd0);
    chk("after_bd",   16'(bd),   16'd0);
    chk("after_bx",   16'(b_x),  16'd320);
    chk("after_by",   16'(b_y),  16'd436);
    chk("after_dx",   16'(b_dx), 16'd1);
    chk("after_dy",   16'(b_dy), 16'd0);
    // Back in HOLD: ball follows paddle again
    tick_once();
    chk("rehold_bx", 16'(b_x), 16'd500);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
